// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: assembles start/8 data/parity/stop frames into a byte with stall timeout.
// Define PS2_PARITY_CHECK_EN to make odd parity part of the accept decision.
module ps2_frame_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       kb_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [TmoW-1:0] TmoAbort = TmoW'(TIMEOUT_CYCLES - 2);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParityCheck = 1'b1;
`else
  localparam bit ParityCheck = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  state_e          state_q, state_d;
  logic [9:0]      shift_q, shift_d;   // {stop, parity, data[7:0]} once complete
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      scan_code_q, scan_code_d;
  logic            scan_valid_q, scan_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_ok, frame_good;

  assign parity_ok  = ~ParityCheck | (^shift_q[8:0]);
  assign frame_good = shift_q[9] & parity_ok;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_d        = tmo_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sample_en && !kb_data) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      end
      StShift: begin
        if (sample_en) begin
          shift_d   = {kb_data, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tmo_d     = '0;
          if (bit_cnt_q == 4'd9) state_d = StCheck;
        end else if (tmo_q == TmoAbort) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
          tmo_d       = '0;
          bit_cnt_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (frame_good) begin
          scan_code_d  = shift_q[7:0];
          scan_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Randomized bench for ps2_frame_receiver against a frame-level reference model.
module tb_ps2_frame_receiver;

  localparam int unsigned Tmo = 1000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParityCheck = 1'b1;
`else
  localparam bit ParityCheck = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_en = 1'b0;
  logic       kb_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_strobe = 0;

  typedef struct {bit err; logic [7:0] code; int cyc;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] exp_code = 8'h00;

  ps2_frame_receiver #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .kb_data   (kb_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every output pulse must match the next expected frame outcome, at its exact cycle.
  always @(negedge clk) begin
    if (!rst) begin
      exp_code = 8'h00;
    end else if (scan_valid || frame_err) begin
      check("exclusive", 32'(scan_valid & frame_err), 0);
      if (exp_q.size() == 0) begin
        check("stray_pulse", {30'd0, scan_valid, frame_err}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("kind_err", 32'(frame_err), 32'(e.err));
        check("latency", cyc, e.cyc);
        if (!e.err) exp_code = e.code;
        check("scan_code", 32'(scan_code), 32'(exp_code));
        check("busy_after", 32'(busy), 0);
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      kb_data = 1'($urandom);
    end
  endtask

  task automatic strobe(input bit b);
    @(posedge clk); #1;
    sample_en   = 1'b1;
    kb_data     = b;
    last_strobe = cyc;
    @(posedge clk); #1;
    sample_en = 1'b0;
    kb_data   = 1'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                            input int max_gap);
    logic [10:0] f;
    bit          par, good;
    par = (~^d) ^ bad_par;
    f   = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      gap($urandom_range(0, max_gap));
      strobe(f[i]);
      if (i == 0) check("busy_start", 32'(busy), 1);
    end
    good = stop && (!ParityCheck || (($countones(d) + int'(par)) % 2 == 1));
    exp_q.push_back('{err: !good, code: d, cyc: last_strobe + 2});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("pending", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_code", 32'(scan_code), 0);
    check("rst_flags", {29'd0, scan_valid, frame_err, busy}, 0);
    rst = 1'b1;
    gap(2);
    strobe(1'b1);  // idle line high: no frame, no error
    gap(2);
    check("idle_busy", 32'(busy), 0);

    // 0x1C then 0xF0 back-to-back, bad parity, bad stop
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    drain();
    send_frame(8'h1C, 1'b1, 1'b1, 1);
    drain();
    send_frame(8'hF0, 1'b0, 1'b0, 1);
    drain();

    // Stall after start + 4 data bits
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'($urandom));
    exp_q.push_back('{err: 1'b1, code: 8'h00, cyc: last_strobe + Tmo});
    while (cyc < last_strobe + Tmo - 1) begin
      @(posedge clk); #1;
    end
    check("busy_pre_tmo", 32'(busy), 1);
    drain();
    send_frame(8'h1C, 1'b0, 1'b1, 2);
    drain();

    // Asynchronous reset after 6 bits of a frame
    strobe(1'b0);
    for (int i = 0; i < 5; i++) strobe(1'($urandom));
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_code", 32'(scan_code), 0);
    check("mid_rst_flags", {29'd0, scan_valid, frame_err, busy}, 0);
    gap(3);
    rst = 1'b1;
    gap(1);
    send_frame(8'hF0, 1'b0, 1'b1, 1);
    drain();

    // Randomized frames with occasional faults, idle strobes and strobes during CHECK
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) strobe(1'b1);
      send_frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0, 3);
      if ($urandom_range(0, 3) == 0) begin
        sample_en = 1'b1;
        kb_data   = 1'b0;
        @(posedge clk); #1;
        sample_en = 1'b0;
      end
    end
    drain();
    check("end_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
